// File: rtl/dispatch_scheduler_pkg.sv
// dispatch_scheduler_pkg
// Shared types and constants for the dispatch stage: register index width,
// scoreboard size, execution-pipe select bits, the decode-to-dispatch payload
// and the dispatch FSM state encoding.
package dispatch_scheduler_pkg;

    localparam int REG_WIDTH = 5;
    localparam int NUM_REGS  = 32;

    // Bit positions inside ctrl.exe_pipe; exactly one is set for a real
    // instruction, none for a bubble.
    localparam int EXE_PIPE_ALU_BIT = 0;
    localparam int EXE_PIPE_LSU_BIT = 1;

    typedef enum logic {
        DS_READY       = 1'b0,
        DS_BRANCH_WAIT = 1'b1
    } ds_state_e;

    typedef struct packed {
        logic [1:0] exe_pipe;
        logic       register_write;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t                ctrl;
        logic [REG_WIDTH-1:0] rd;
        logic [REG_WIDTH-1:0] a1;
        logic [REG_WIDTH-1:0] a2;
        logic [31:0]          imm;
        logic [31:0]          pc;
    } id_dispatcher_inf_t;

    // Any instruction that redirects fetch and must resolve before the next
    // instruction is allowed to issue.
    function automatic logic is_ctrl_transfer(input ctrl_t c);
        return c.branch | c.jal | c.jalr;
    endfunction

endpackage

// File: rtl/dispatch_scheduler_register_scoreboard.sv
// register_scoreboard
// One busy bit per architectural register. Two writeback clear ports, one
// issue set port (set wins over clear on the same index), three read ports
// for the operands and destination of the instruction at dispatch.
// Ports:
//   clk, rst                 clock, async active-high reset
//   clr_a_valid/clr_a_idx    first clear port (ALU writeback)
//   clr_b_valid/clr_b_idx    second clear port (LSU writeback)
//   set_valid/set_idx        set port (issue of a register-writing instr)
//   rd_a1_idx/busy_a1        read port for source 1
//   rd_a2_idx/busy_a2        read port for source 2
//   rd_rd_idx/busy_rd        read port for the destination
//   busy                     full scoreboard vector
module register_scoreboard
    import dispatch_scheduler_pkg::*;
#(
    parameter int NUM_REGS = dispatch_scheduler_pkg::NUM_REGS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_a_valid,
    input  logic [REG_WIDTH-1:0] clr_a_idx,
    input  logic                 clr_b_valid,
    input  logic [REG_WIDTH-1:0] clr_b_idx,
    input  logic                 set_valid,
    input  logic [REG_WIDTH-1:0] set_idx,
    input  logic [REG_WIDTH-1:0] rd_a1_idx,
    input  logic [REG_WIDTH-1:0] rd_a2_idx,
    input  logic [REG_WIDTH-1:0] rd_rd_idx,
    output logic                 busy_a1,
    output logic                 busy_a2,
    output logic                 busy_rd,
    output logic [NUM_REGS-1:0]  busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clears first, then the set, so an issue writing the same register
    // that is being written back this cycle keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_a_valid) busy_d[clr_a_idx] = 1'b0;
        if (clr_b_valid) busy_d[clr_b_idx] = 1'b0;
        if (set_valid)   busy_d[set_idx]   = 1'b1;
        busy_d[0] = 1'b0;  // x0 is never busy
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Registered state only: a writeback is visible to dispatch next cycle.
    assign busy_a1 = busy_q[rd_a1_idx];
    assign busy_a2 = busy_q[rd_a2_idx];
    assign busy_rd = busy_q[rd_rd_idx];
    assign busy    = busy_q;

endmodule

// File: rtl/dispatch_scheduler.sv
// dispatch_scheduler
// Issues decoded instructions to the ALU or LSU pipe through one registered
// slot per pipe. Holds decode (dispatch_stall) on RAW/WAW hazards, a full
// target slot, or while a control transfer is unresolved.
// Ports:
//   clk, rst                     clock, async active-high reset
//   flush                        core redirect, suppresses issue this cycle
//   id_dispatcher_inf            decoded instruction (bubble if exe_pipe==0)
//   dispatch_stall               instruction present but not issued
//   alu_dispatch_valid/ready/inf ALU slot handshake and payload
//   lsu_dispatch_valid/ready/inf LSU slot handshake and payload
//   alu_wb_valid/alu_wb_rd       ALU writeback, clears busy bit
//   lsu_wb_valid/lsu_wb_rd       LSU writeback, clears busy bit
//   branch_resolved              control transfer completed in the ALU
//   busy_regs                    scoreboard vector
// Handshake: a slot transfers on a cycle where valid & ready are both high.
// While ready is low, valid stays high and the payload is held unchanged.
// A slot may be reloaded in the same cycle it is consumed.
module dispatch_scheduler
    import dispatch_scheduler_pkg::*;
#(
    parameter int NUM_REGS = dispatch_scheduler_pkg::NUM_REGS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  id_dispatcher_inf_t   id_dispatcher_inf,
    output logic                 dispatch_stall,
    output logic                 alu_dispatch_valid,
    input  logic                 alu_dispatch_ready,
    output id_dispatcher_inf_t   alu_dispatch_inf,
    output logic                 lsu_dispatch_valid,
    input  logic                 lsu_dispatch_ready,
    output id_dispatcher_inf_t   lsu_dispatch_inf,
    input  logic                 alu_wb_valid,
    input  logic [REG_WIDTH-1:0] alu_wb_rd,
    input  logic                 lsu_wb_valid,
    input  logic [REG_WIDTH-1:0] lsu_wb_rd,
    input  logic                 branch_resolved,
    output logic [NUM_REGS-1:0]  busy_regs
);

    ds_state_e          state_q;
    logic               alu_valid_q;
    logic               lsu_valid_q;
    id_dispatcher_inf_t alu_inf_q;
    id_dispatcher_inf_t lsu_inf_q;

    logic iv;
    logic to_alu;
    logic to_lsu;
    logic alu_can_accept;
    logic lsu_can_accept;
    logic busy_a1;
    logic busy_a2;
    logic busy_rd;
    logic hazard;
    logic issue;
    logic issue_alu;
    logic issue_lsu;
    logic set_valid;

    assign iv     = |id_dispatcher_inf.ctrl.exe_pipe;
    assign to_alu = id_dispatcher_inf.ctrl.exe_pipe[EXE_PIPE_ALU_BIT];
    assign to_lsu = id_dispatcher_inf.ctrl.exe_pipe[EXE_PIPE_LSU_BIT];

    assign alu_can_accept = !alu_valid_q | alu_dispatch_ready;
    assign lsu_can_accept = !lsu_valid_q | lsu_dispatch_ready;

    // WAW only matters when the instruction actually writes rd.
    assign hazard = busy_a1 | busy_a2 | (id_dispatcher_inf.ctrl.register_write & busy_rd);

    assign issue = iv & !flush & (state_q == DS_READY) & !hazard &
                   ((to_alu & alu_can_accept) | (to_lsu & lsu_can_accept));
    assign issue_alu = issue & to_alu;
    assign issue_lsu = issue & to_lsu;

    assign dispatch_stall = iv & !issue;

    assign set_valid = issue & id_dispatcher_inf.ctrl.register_write &
                       (id_dispatcher_inf.rd != '0);

    register_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .clr_a_valid (alu_wb_valid),
        .clr_a_idx   (alu_wb_rd),
        .clr_b_valid (lsu_wb_valid),
        .clr_b_idx   (lsu_wb_rd),
        .set_valid   (set_valid),
        .set_idx     (id_dispatcher_inf.rd),
        .rd_a1_idx   (id_dispatcher_inf.a1),
        .rd_a2_idx   (id_dispatcher_inf.a2),
        .rd_rd_idx   (id_dispatcher_inf.rd),
        .busy_a1     (busy_a1),
        .busy_a2     (busy_a2),
        .busy_rd     (busy_rd),
        .busy        (busy_regs)
    );

    // Slots: a new issue takes priority over the drain, which gives the
    // back-to-back handoff when the old entry is consumed the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_valid_q <= 1'b0;
            alu_inf_q   <= '0;
            lsu_valid_q <= 1'b0;
            lsu_inf_q   <= '0;
        end else begin
            if (issue_alu) begin
                alu_valid_q <= 1'b1;
                alu_inf_q   <= id_dispatcher_inf;
            end else if (alu_dispatch_ready) begin
                alu_valid_q <= 1'b0;
            end
            if (issue_lsu) begin
                lsu_valid_q <= 1'b1;
                lsu_inf_q   <= id_dispatcher_inf;
            end else if (lsu_dispatch_ready) begin
                lsu_valid_q <= 1'b0;
            end
        end
    end

    // Control-transfer gate. Flush only redirects fetch; it never drops
    // slot contents or scoreboard bits, since those are older work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DS_READY;
        end else begin
            case (state_q)
                DS_READY: begin
                    if (issue && is_ctrl_transfer(id_dispatcher_inf.ctrl)) begin
                        state_q <= DS_BRANCH_WAIT;
                    end
                end
                DS_BRANCH_WAIT: begin
                    if (branch_resolved || flush) begin
                        state_q <= DS_READY;
                    end
                end
                default: state_q <= DS_READY;
            endcase
        end
    end

    assign alu_dispatch_valid = alu_valid_q;
    assign alu_dispatch_inf   = alu_inf_q;
    assign lsu_dispatch_valid = lsu_valid_q;
    assign lsu_dispatch_inf   = lsu_inf_q;

endmodule

// File: doc/dispatch_scheduler.md
# dispatch_scheduler

- Sits between instruction decode and the ALU and LSU execution pipes.
- Takes the registered decode output (`id_dispatcher_inf`) and tracks destination registers in flight with a register scoreboard.
- Issues each instruction to its target pipe through a registered valid/ready slot, and holds decode via `dispatch_stall` on RAW/WAW hazards, pipe backpressure, or an unresolved control transfer.

## Interface

Parameters:
- `NUM_REGS`, default 32: architectural register count; the scoreboard has this many bits.
- `REG_WIDTH`, default 5 (from package): register index width.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  core redirect; same signal decode sees.
- `id_dispatcher_inf`  in  `id_dispatcher_inf_t`  decoded instruction; a bubble when `ctrl.exe_pipe == 0`.
- `dispatch_stall`  out  1  to core; holds IF/ID when the current instruction is not issued.
- `alu_dispatch_valid`  out  1  ALU slot holds an instruction.
- `alu_dispatch_ready`  in  1  ALU accepts the slot this cycle.
- `alu_dispatch_inf`  out  `id_dispatcher_inf_t`  ALU slot payload.
- `lsu_dispatch_valid`, `lsu_dispatch_ready`, `lsu_dispatch_inf`: same as the ALU trio, for the LSU.
- `alu_wb_valid`  in  1  ALU writeback; clears `busy[alu_wb_rd]`.
- `alu_wb_rd`  in  `REG_WIDTH`  ALU writeback register index.
- `lsu_wb_valid`  in  1  LSU writeback; clears `busy[lsu_wb_rd]`.
- `lsu_wb_rd`  in  `REG_WIDTH`  LSU writeback register index.
- `branch_resolved`  in  1  one-cycle pulse from the ALU when a branch/jal/jalr completes.
- `busy_regs`  out  `NUM_REGS`  scoreboard state, for debug and verification.

## Operation

- Instruction valid (`iv`): `|ctrl.exe_pipe`. Target pipe: `EXE_PIPE_ALU_BIT` or `EXE_PIPE_LSU_BIT`; exactly one bit is set by construction.
- Hazard: `busy[a1] | busy[a2] | (ctrl.register_write & busy[rd])`.
  - `busy[0]` is hardwired to 0, so x0 never stalls.
- Slot can accept: `!valid_q | ready`.
- `issue` = `iv & !flush & state==DS_READY & !hazard & target slot can accept`.
- On `issue`:
  - Target slot loads the full `id_dispatcher_inf` payload and sets valid to 1.
  - Sets `busy[rd]` if `ctrl.register_write` and `rd != 0`.
  - If `branch | jal | jalr`, the FSM moves to `DS_BRANCH_WAIT`.
- Slot valid clears on `valid & ready` when no new issue targets that slot in the same cycle. Issue and consume in the same cycle hand off back-to-back.
- `dispatch_stall` = `iv & !issue`; combinational.
- FSM:
  - `DS_READY` → `DS_BRANCH_WAIT` on issue of a control transfer.
  - `DS_BRANCH_WAIT` → `DS_READY` on `branch_resolved` or `flush`.
  - No issue occurs while in `DS_BRANCH_WAIT`.
- `flush`:
  - Suppresses issue that cycle and forces the state to `DS_READY`.
  - Does not touch the slots or the scoreboard. Slot contents are always older than the resolving branch, so they must complete.
- Scoreboard update priority within one cycle:
  - Writeback clears apply first; both ports may clear, including the same index.
  - The issue set then applies, so set wins over clear on the same index.

## Timing

- Reset values:
  - `busy` all 0.
  - Both slot valids 0; payloads 0.
  - State `DS_READY`.
  - `dispatch_stall` 0, because decode resets to a bubble.
- Issue latency: an instruction issued in cycle N is visible on `*_dispatch_valid` in cycle N+1.
- Writeback clear is registered. A writeback in cycle N allows a dependent instruction to issue in cycle N+1 at the earliest (no same-cycle bypass).
- `branch_resolved` in cycle N allows the next instruction to issue in cycle N+1.
- Slot valid is held, and its payload is stable, while `ready` is low; the consumer may not rely on valid dropping.
- Reset asserted mid-operation clears all state immediately (asynchronous). In-flight writebacks after reset are ignored, because the bits are already 0.

## Structure

- Shared package (`defines.svh`):
  - `ds_state_e` {`DS_READY`, `DS_BRANCH_WAIT`}.
  - `NUM_REGS`.
  - Existing `id_dispatcher_inf_t`, `EXE_PIPE_ALU_BIT`, `EXE_PIPE_LSU_BIT`, `REG_WIDTH`.
- Sub-module `register_scoreboard`: two clear ports, one set port, two read ports plus an rd read port, and the full vector output.
- Slot registers and the FSM live in the top level.

## Test plan

- RAW: `add x5,x1,x2` then `addi x6,x5,1` → second stalls until `alu_wb_valid` with `alu_wb_rd=5` in cycle N; it issues in N+1.
- x0: `addi x0,x1,3` then `add x7,x0,x0` → `busy_regs` unchanged; both issue on consecutive cycles with no stall.
- Backpressure: `lsu_dispatch_ready=0` with one load held; second load → `dispatch_stall=1`. Raise ready → load handoff in the same cycle; `lsu_dispatch_valid` stays 1 with the new payload.
- Branch: `beq` issued → state `DS_BRANCH_WAIT`; independent `addi` stalls. `branch_resolved` in cycle N → `addi` issues in N+1.
- Flush in `DS_BRANCH_WAIT` with an LSU slot valid and `busy[9]=1` → state `DS_READY`, no issue that cycle, slot and `busy[9]` preserved.
- Same-cycle `alu_wb_rd=4` clear and issue of `add x4,...` → `busy[4]` remains 1.
